// File: rtl/byte_msg_packer_if.sv
// Source-slot bus between a byte_msg_packer and its byte producer / slave-FIFO arbiter.
// Signal directions are named from the packer's point of view.
interface byte_msg_packer_if;
  logic [7:0]  din_i;
  logic        din_valid_i;
  logic        din_last_i;
  logic        din_ready_o;
  logic        rd_req_i;
  logic        msg_start_i;
  logic [15:0] fifo_q_o;
  logic        got_full_msg_o;
  logic [7:0]  msg_len_o;
  logic        parity_out_o;
  logic        err_o;

  modport master (
    output din_i, din_valid_i, din_last_i, rd_req_i, msg_start_i,
    input  din_ready_o, fifo_q_o, got_full_msg_o, msg_len_o, parity_out_o, err_o
  );

  modport slave (
    input  din_i, din_valid_i, din_last_i, rd_req_i, msg_start_i,
    output din_ready_o, fifo_q_o, got_full_msg_o, msg_len_o, parity_out_o, err_o
  );
endinterface

// File: rtl/byte_msg_packer.sv
// Packs a byte stream into 16-bit words, buffers whole messages and queues
// {word count, odd-byte flag} per message for one arbiter source slot.
module byte_msg_packer #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LENQ_LOG2  = 3
) (
  input logic              clk_i,
  input logic              rst_ni,
  byte_msg_packer_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LENQ  = 1 << LENQ_LOG2;

  localparam logic [0:0] ST_EVEN = 1'b0;
  localparam logic [0:0] ST_ODD  = 1'b1;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   WCNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   WCNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [LENQ_LOG2-1:0]  LPTR_ONE   = LENQ_LOG2'(1);
  localparam logic [LENQ_LOG2:0]    LCNT_ONE   = (LENQ_LOG2 + 1)'(1);
  localparam logic [LENQ_LOG2:0]    LCNT_FULL  = (LENQ_LOG2 + 1)'(LENQ);
  localparam logic [7:0]            MAX_WORDS  = 8'd255;

  logic [15:0] word_mem_q [DEPTH];
  logic [8:0]  len_mem_q  [LENQ];

  logic [0:0]            state_q, state_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            msg_words_q, msg_words_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   word_cnt_q, word_cnt_d;
  logic [LENQ_LOG2-1:0]  lq_wr_ptr_q, lq_wr_ptr_d, lq_rd_ptr_q, lq_rd_ptr_d;
  logic [LENQ_LOG2:0]    lq_cnt_q, lq_cnt_d;
  logic                  din_ready_q, din_ready_d;
  logic                  err_q, err_d;

  logic        accept_s;
  logic        word_wr_s;
  logic [15:0] wdata_s;
  logic [7:0]  new_words_s;
  logic        commit_s;
  logic        commit_odd_s;
  logic        rd_ok_s;
  logic        start_ok_s;

  assign accept_s     = bus.din_valid_i & din_ready_q;
  assign new_words_s  = msg_words_q + 8'd1;
  assign commit_s     = word_wr_s & (bus.din_last_i | (new_words_s == MAX_WORDS));
  assign commit_odd_s = (state_q == ST_EVEN);
  assign rd_ok_s      = bus.rd_req_i & (word_cnt_q != '0);
  assign start_ok_s   = bus.msg_start_i & (lq_cnt_q != '0);

  // Pair FSM: hold the high byte, emit a word on the second byte or a padded word on an odd LAST
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    word_wr_s = 1'b0;
    wdata_s   = 16'h0000;
    if (accept_s) begin
      case (state_q)
        ST_ODD: begin
          word_wr_s = 1'b1;
          wdata_s   = {hi_q, bus.din_i};
          state_d   = ST_EVEN;
        end
        ST_EVEN: begin
          if (bus.din_last_i) begin
            word_wr_s = 1'b1;
            wdata_s   = {bus.din_i, 8'h00};
          end else begin
            hi_d    = bus.din_i;
            state_d = ST_ODD;
          end
        end
        default: state_d = ST_EVEN;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Pointer, occupancy, message-length and status next-state
  always_comb begin
    wr_ptr_d    = word_wr_s  ? (wr_ptr_q + PTR_ONE)     : wr_ptr_q;
    rd_ptr_d    = rd_ok_s    ? (rd_ptr_q + PTR_ONE)     : rd_ptr_q;
    lq_wr_ptr_d = commit_s   ? (lq_wr_ptr_q + LPTR_ONE) : lq_wr_ptr_q;
    lq_rd_ptr_d = start_ok_s ? (lq_rd_ptr_q + LPTR_ONE) : lq_rd_ptr_q;

    case ({word_wr_s, rd_ok_s})
      2'b10:   word_cnt_d = word_cnt_q + WCNT_ONE;
      2'b01:   word_cnt_d = word_cnt_q - WCNT_ONE;
      default: word_cnt_d = word_cnt_q;
    endcase

    case ({commit_s, start_ok_s})
      2'b10:   lq_cnt_d = lq_cnt_q + LCNT_ONE;
      2'b01:   lq_cnt_d = lq_cnt_q - LCNT_ONE;
      default: lq_cnt_d = lq_cnt_q;
    endcase

    if (commit_s) begin
      msg_words_d = 8'd0;
    end else if (word_wr_s) begin
      msg_words_d = new_words_s;
    end else begin
      msg_words_d = msg_words_q;
    end

    // Decided on next-state values so a byte accepted next cycle always has room
    din_ready_d = (word_cnt_d != WCNT_FULL) &&
                  !((lq_cnt_d == LCNT_FULL) && (msg_words_d == 8'd0));

    err_d = err_q | (bus.rd_req_i & (word_cnt_q == '0)) |
                    (bus.msg_start_i & (lq_cnt_q == '0));
  end

  // Control and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_EVEN;
      hi_q        <= 8'h00;
      msg_words_q <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      word_cnt_q  <= '0;
      lq_wr_ptr_q <= '0;
      lq_rd_ptr_q <= '0;
      lq_cnt_q    <= '0;
      din_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      msg_words_q <= msg_words_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      word_cnt_q  <= word_cnt_d;
      lq_wr_ptr_q <= lq_wr_ptr_d;
      lq_rd_ptr_q <= lq_rd_ptr_d;
      lq_cnt_q    <= lq_cnt_d;
      din_ready_q <= din_ready_d;
      err_q       <= err_d;
    end
  end

  // Storage arrays; contents are only visible while the matching occupancy is non-zero
  always_ff @(posedge clk_i) begin
    if (word_wr_s) begin
      word_mem_q[wr_ptr_q] <= wdata_s;
    end
    if (commit_s) begin
      len_mem_q[lq_wr_ptr_q] <= {new_words_s, commit_odd_s};
    end
  end

  assign bus.din_ready_o    = din_ready_q;
  assign bus.err_o          = err_q;
  assign bus.got_full_msg_o = (lq_cnt_q != '0);
  assign bus.fifo_q_o       = (word_cnt_q != '0) ? word_mem_q[rd_ptr_q] : 16'h0000;
  assign bus.msg_len_o      = (lq_cnt_q != '0) ? len_mem_q[lq_rd_ptr_q][8:1] : 8'd0;
  assign bus.parity_out_o   = (lq_cnt_q != '0) ? len_mem_q[lq_rd_ptr_q][0] : 1'b0;

endmodule
